// File: rtl/i2c_master.sv
// Single-master I2C engine: START, 7-bit address + R/W, multi-byte write/read
// burst with ACK checking, STOP. Open-drain SDA via sda_oe, push-pull SCL.
module i2c_master #(
  parameter  int CLK_DIV   = 4,
  parameter  int MAX_BYTES = 4,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [CNT_W-1:0] len,
  input  logic [7:0]       wdata,
  output logic             wr_ack,
  output logic [7:0]       rdata,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             scl,
  output logic             sda_oe,
  input  logic             sda_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WRITE, WACK, READ, RACK, STOP
  } state_t;

  state_t           state_q, state_n;
  logic [1:0]       q_q, q_n;
  logic [2:0]       bit_q, bit_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [7:0]       sh_q, sh_n;
  logic [CNT_W-1:0] left_q, left_n;
  logic             rw_q, rw_n;
  logic             tick;
  logic             start_write;
  logic [CNT_W-1:0] len_c;

  logic       wr_ack_n, rd_valid_n, busy_n, done_n, nack_n, scl_n, sda_oe_n;
  logic [7:0] rdata_n;

  assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
  assign len_c = (len > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : len;

  // Next-state logic; line outputs are then decoded from the next state so
  // that scl/sda_oe are registered yet aligned with the quarter they belong to.
  always_comb begin
    state_n     = state_q;
    q_n         = q_q;
    bit_n       = bit_q;
    sh_n        = sh_q;
    left_n      = left_q;
    rw_n        = rw_q;
    nack_n      = nack;
    busy_n      = busy;
    rdata_n     = rdata;
    done_n      = 1'b0;
    wr_ack_n    = 1'b0;
    rd_valid_n  = 1'b0;
    start_write = 1'b0;
    div_n       = tick ? '0 : div_q + DIV_W'(1);

    if (state_q == IDLE) begin
      div_n = '0;
      if (init) begin
        sh_n    = {addr, rw};
        rw_n    = rw;
        left_n  = len_c;
        nack_n  = 1'b0;
        busy_n  = 1'b1;
        q_n     = '0;
        bit_n   = 3'd7;
        state_n = START;
      end
    end else if (tick) begin
      q_n = q_q + 2'd1;
      case (state_q)
        START: begin
          if (q_q == 2'd1) begin
            q_n     = '0;
            bit_n   = 3'd7;
            state_n = ADDR;
          end
        end
        ADDR, WRITE: begin
          if (q_q == 2'd3) begin
            if (bit_q == 3'd0) begin
              state_n = (state_q == ADDR) ? AACK : WACK;
            end else begin
              bit_n = bit_q - 3'd1;
              sh_n  = {sh_q[6:0], 1'b0};
            end
          end
        end
        AACK, WACK: begin
          if (q_q == 2'd2 && sda_i) nack_n = 1'b1;
          if (q_q == 2'd3) begin
            if (nack || left_q == '0) begin
              state_n = STOP;
            end else if (state_q == AACK && rw_q) begin
              state_n = READ;
              bit_n   = 3'd7;
            end else begin
              start_write = 1'b1;
            end
          end
        end
        READ: begin
          if (q_q == 2'd2) begin
            sh_n = {sh_q[6:0], sda_i};
            if (bit_q == 3'd0) begin
              rdata_n    = {sh_q[6:0], sda_i};
              rd_valid_n = 1'b1;
              left_n     = left_q - CNT_W'(1);
            end
          end
          if (q_q == 2'd3) begin
            if (bit_q == 3'd0) state_n = RACK;
            else               bit_n   = bit_q - 3'd1;
          end
        end
        RACK: begin
          if (q_q == 2'd3) begin
            if (left_q != '0) begin
              state_n = READ;
              bit_n   = 3'd7;
            end else begin
              state_n = STOP;
            end
          end
        end
        STOP: begin
          if (q_q == 2'd3) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // The byte is latched in the same edge that raises wr_ack, so the
    // front-end may move on to the next byte as soon as it sees the pulse.
    if (start_write) begin
      state_n  = WRITE;
      bit_n    = 3'd7;
      sh_n     = wdata;
      wr_ack_n = 1'b1;
      left_n   = left_q - CNT_W'(1);
    end

    scl_n    = 1'b1;
    sda_oe_n = 1'b0;
    case (state_n)
      START: sda_oe_n = (q_n == 2'd1);
      ADDR, WRITE: begin
        scl_n    = q_n[1];
        sda_oe_n = ~sh_n[7];
      end
      AACK, WACK, READ: scl_n = q_n[1];
      RACK: begin
        scl_n    = q_n[1];
        sda_oe_n = (left_n != '0);
      end
      STOP: begin
        scl_n    = q_n[1];
        sda_oe_n = (q_n != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      sh_q     <= '0;
      left_q   <= '0;
      rw_q     <= 1'b0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      state_q  <= state_n;
      q_q      <= q_n;
      bit_q    <= bit_n;
      div_q    <= div_n;
      sh_q     <= sh_n;
      left_q   <= left_n;
      rw_q     <= rw_n;
      wr_ack   <= wr_ack_n;
      rd_valid <= rd_valid_n;
      rdata    <= rdata_n;
      busy     <= busy_n;
      done     <= done_n;
      nack     <= nack_n;
      scl      <= scl_n;
      sda_oe   <= sda_oe_n;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: bus-level slave model on SCL/SDA plus scoreboard
// queues for bytes seen on the wire, read data and master ACK bits.
module tb_i2c_master;
  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 4;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             init = 1'b0;
  logic [6:0]       addr = '0;
  logic             rw = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [7:0]       wdata = '0;
  logic             wr_ack, rd_valid, busy, done, nack, scl, sda_oe;
  logic [7:0]       rdata;
  logic             slave_low = 1'b0;
  logic             sda_line;

  assign sda_line = ~(sda_oe | slave_low);

  i2c_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .init(init), .addr(addr), .rw(rw), .len(len),
    .wdata(wdata), .wr_ack(wr_ack), .rdata(rdata), .rd_valid(rd_valid),
    .busy(busy), .done(done), .nack(nack), .scl(scl), .sda_oe(sda_oe),
    .sda_i(sda_line)
  );

  always #5 clk = ~clk;

  int total = 0, pass_cnt = 0, fail_cnt = 0;
  int wr_cnt = 0, rd_cnt = 0, busy_cyc = 0, done_cnt = 0, overlap = 0;

  logic [7:0] exp_sda[$];
  logic [7:0] slave_rd[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wq[$];
  logic       exp_mack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor and write-data front-end
  always @(negedge clk) begin
    if (wr_ack) begin
      wr_cnt++;
      if (wq.size() != 0) void'(wq.pop_front());
    end
    wdata = (wq.size() != 0) ? wq[0] : 8'h00;
    if (rd_valid) begin
      rd_cnt++;
      if (exp_rd.size() == 0) check("rd_extra", exp_rd.size(), 1);
      else                    check("rdata", rdata, exp_rd.pop_front());
    end
    if (wr_ack && rd_valid) overlap++;
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      check("done_busy", busy, 0);
    end
  end

  // Slave model: ACKs every address except 7'h21, ACKs all written bytes
  logic scl_prev = 1'b1, sda_prev = 1'b1;
  logic in_txn = 1'b0, is_addr = 1'b0, rd_mode = 1'b0;
  int   pos = -1;
  logic [7:0] shift = '0, tx_byte = 8'hFF;

  always @(scl or sda_line or rst) begin
    if (!rst) begin
      in_txn    = 1'b0;
      slave_low = 1'b0;
      pos       = -1;
    end else if (scl !== scl_prev) begin
      if (in_txn && scl === 1'b1) begin
        if (pos >= 0 && pos <= 7) begin
          shift = {shift[6:0], sda_line};
          if (pos == 7 && (is_addr || !rd_mode)) begin
            if (exp_sda.size() == 0) check("sda_extra", exp_sda.size(), 1);
            else                     check("sda_byte", shift, exp_sda.pop_front());
          end
        end else if (pos == 8) begin
          if (is_addr) begin
            is_addr = 1'b0;
            rd_mode = shift[0];
            if (shift[7:1] == 7'h21) in_txn = 1'b0;
            else if (rd_mode) tx_byte = (slave_rd.size() != 0) ? slave_rd.pop_front() : 8'hFF;
          end else if (rd_mode) begin
            if (exp_mack.size() == 0) check("mack_extra", exp_mack.size(), 1);
            else                      check("master_ack", !sda_line, exp_mack.pop_front());
            if (sda_line) in_txn = 1'b0;
            else tx_byte = (slave_rd.size() != 0) ? slave_rd.pop_front() : 8'hFF;
          end
        end
      end else if (in_txn && scl === 1'b0) begin
        pos = (pos == 8) ? 0 : pos + 1;
        if (pos <= 7) slave_low = (!is_addr && rd_mode) ? ~tx_byte[7-pos] : 1'b0;
        else          slave_low = is_addr ? (shift[7:1] != 7'h21) : !rd_mode;
      end
    end else if (scl === 1'b1 && sda_line !== sda_prev) begin
      if (sda_line === 1'b0) begin
        in_txn = 1'b1; is_addr = 1'b1; rd_mode = 1'b0; pos = -1; slave_low = 1'b0;
      end else if (sda_line === 1'b1) begin
        in_txn = 1'b0; slave_low = 1'b0;
      end
    end
    scl_prev = scl;
    sda_prev = sda_line;
  end

  task automatic run_txn(input string name, input logic [6:0] a, input logic r,
                         input logic [CNT_W-1:0] l, input int exp_busy, input int exp_wr,
                         input int exp_rdn, input logic exp_nack, input bit poke);
    int b0, w0, r0, d0, o0;
    bit seen;
    b0 = busy_cyc; w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; o0 = overlap;
    @(negedge clk);
    addr = a; rw = r; len = l; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check({name, "_busy_rise"}, busy, 1);
    if (poke) begin
      repeat (50) @(negedge clk);
      addr = 7'h21; rw = 1'b1; init = 1'b1;
      @(negedge clk);
      init = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    check({name, "_busy_cycles"}, busy_cyc - b0, exp_busy);
    check({name, "_wr_ack_cnt"}, wr_cnt - w0, exp_wr);
    check({name, "_rd_valid_cnt"}, rd_cnt - r0, exp_rdn);
    check({name, "_done_cnt"}, done_cnt - d0, 1);
    check({name, "_overlap"}, overlap - o0, 0);
    check({name, "_nack"}, nack, exp_nack);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_sda_left"}, exp_sda.size(), 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_mack_left"}, exp_mack.size(), 0);
    if (poke) begin
      repeat (30) @(negedge clk);
      check({name, "_no_restart"}, busy, 0);
    end
  endtask

  initial begin : stim
    bit seen;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rdata", rdata, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    exp_sda.push_back(8'hA0); exp_sda.push_back(8'h55);
    wq.push_back(8'h55);
    run_txn("wr1", 7'h50, 1'b0, 3'd1, 156, 1, 0, 1'b0, 1'b0);

    exp_sda.push_back(8'h42);
    run_txn("anack", 7'h21, 1'b0, 3'd1, 84, 0, 0, 1'b1, 1'b0);

    exp_sda.push_back(8'h79);
    slave_rd.push_back(8'hA5); slave_rd.push_back(8'h0F);
    exp_rd.push_back(8'hA5);   exp_rd.push_back(8'h0F);
    exp_mack.push_back(1'b1);  exp_mack.push_back(1'b0);
    run_txn("rd2", 7'h3C, 1'b1, 3'd2, 228, 0, 2, 1'b0, 1'b0);

    // Reset in the low half of write bit 4 (bit value 0, so SDA is pulled)
    exp_sda.push_back(8'hA0); exp_sda.push_back(8'h69);
    wq.push_back(8'h69); wq.push_back(8'h3A);
    @(negedge clk);
    addr = 7'h50; rw = 1'b0; len = 3'd2; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = wr_ack;
    end
    check("mid_wr_ack_seen", seen, 1);
    repeat (26) @(negedge clk);
    check("mid_pre_scl", scl, 0);
    check("mid_pre_sda_oe", sda_oe, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    exp_sda.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_sda.push_back(8'hA0); exp_sda.push_back(8'hC3);
    wq.push_back(8'hC3);
    run_txn("after_rst", 7'h50, 1'b0, 3'd1, 156, 1, 0, 1'b0, 1'b0);

    exp_sda.push_back(8'hA0);
    exp_sda.push_back(8'h11); exp_sda.push_back(8'h22);
    exp_sda.push_back(8'h33); exp_sda.push_back(8'h44);
    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
    wq.push_back(8'h5A); wq.push_back(8'h6B); wq.push_back(8'h7C);
    run_txn("clamp", 7'h50, 1'b0, 3'd7, 372, 4, 0, 1'b0, 1'b1);
    wq.delete();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
